// File: rtl/shared_adder_scheduler_pkg.sv
// Shared definitions for the shared-adder scheduler: byte width, FSM states and
// the 4-bit carry-lookahead helper used to build the byte adder.
package shared_adder_scheduler_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Returns {carry_out, sum[3:0]} with all carries computed by lookahead.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/hybrid_adder.sv
// 8-bit adder: two 4-bit lookahead blocks with the nibble carry rippled between them.
module hybrid_adder
  import shared_adder_scheduler_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_lo;
  logic [4:0] w_hi;

  assign w_lo   = cla4(i_a[3:0], i_b[3:0], i_cin);
  assign w_hi   = cla4(i_a[7:4], i_b[7:4], w_lo[4]);
  assign o_sum  = {w_hi[3:0], w_lo[3:0]};
  assign o_cout = w_hi[4];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr (mod NREQ) wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_gnt_idx
);

  logic [IDW-1:0] w_idx;
  logic           w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(i_ptr) + int'(k)) % int'(NREQ));
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/shared_adder_scheduler.sv
// Time-shares one 8-bit adder among NREQ requesters; each multi-byte add runs
// LSB byte first over NBEAT cycles with the carry registered between beats.
module shared_adder_scheduler
  import shared_adder_scheduler_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBEAT = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*BYTE_W*NBEAT-1:0]  req_a,
  input  logic [NREQ*BYTE_W*NBEAT-1:0]  req_b,
  input  logic [NREQ-1:0]               req_cin,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [IDW-1:0]                resp_id,
  output logic [BYTE_W*NBEAT-1:0]       resp_sum,
  output logic                          resp_cout,
  output logic                          busy
);

  localparam int unsigned W  = BYTE_W * NBEAT;
  localparam int unsigned BW = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  state_e          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [BW-1:0]   r_beat;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_cin;
  logic            r_valid;
  logic [IDW-1:0]  r_id;
  logic [W-1:0]    r_sum;
  logic            r_cout;

  logic [NREQ-1:0]   w_gnt;
  logic [IDW-1:0]    w_gnt_idx;
  logic [IDW-1:0]    w_ptr_nxt;
  logic [BYTE_W-1:0] w_a_byte;
  logic [BYTE_W-1:0] w_b_byte;
  logic [BYTE_W-1:0] w_sum_byte;
  logic              w_cy_in;
  logic              w_cy_out;
  logic              w_last;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_a_byte = r_a[BYTE_W*r_beat +: BYTE_W];
  assign w_b_byte = r_b[BYTE_W*r_beat +: BYTE_W];
  assign w_cy_in  = (r_beat == '0) ? r_cin : r_carry;
  assign w_last   = (r_beat == BW'(NBEAT - 1));
  assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  hybrid_adder u_adder (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (w_cy_in),
    .o_sum  (w_sum_byte),
    .o_cout (w_cy_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_beat  <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_a     <= req_a[W*w_gnt_idx +: W];
            r_b     <= req_b[W*w_gnt_idx +: W];
            r_cin   <= req_cin[w_gnt_idx];
            r_id    <= w_gnt_idx;
            r_beat  <= '0;
            r_carry <= 1'b0;
            r_ptr   <= w_ptr_nxt;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[BYTE_W*r_beat +: BYTE_W] <= w_sum_byte;
          r_carry                        <= w_cy_out;
          r_beat                         <= r_beat + 1'b1;
          if (w_last) begin
            r_cout  <= w_cy_out;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Grant is visible only while idle; reset masks it so nothing is accepted.
  assign req_ready  = (r_state == S_IDLE && !rst) ? w_gnt : '0;
  assign resp_valid = r_valid;
  assign resp_id    = r_id;
  assign resp_sum   = r_sum;
  assign resp_cout  = r_cout;
  assign busy       = (r_state != S_IDLE);

endmodule
